// File: rtl/median_window_sequencer.sv
// Front-end controller for the chained median pipeline: issues one config token
// set per window, forwards BUFF_SIZE pixels, retires results and bounds windows in flight.
module median_window_sequencer #(
  parameter logic [10:0] BUFF_SIZE     = 11'd8,
  parameter int unsigned BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter logic [9:0]  MEDIAN_POS    = 10'd4,
  parameter logic [7:0]  DEFAULT_PIVOT = 8'd127,
  parameter int unsigned MAX_INFLIGHT  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_px,
  output logic                     in_px_rd,
  input  logic                     in_px_empty,
  output logic [7:0]               out_px,
  output logic                     out_px_wr,
  input  logic                     out_px_full,
  output logic [7:0]               out_pivot,
  output logic                     out_pivot_wr,
  input  logic                     out_pivot_full,
  output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
  output logic                     out_buff_size_wr,
  input  logic                     out_buff_size_full,
  output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
  output logic                     out_median_pos_wr,
  input  logic                     out_median_pos_full,
  output logic [7:0]               out_second_median_value,
  output logic                     out_second_median_value_wr,
  input  logic                     out_second_median_value_full,
  input  logic [7:0]               in_median,
  output logic                     in_median_rd,
  input  logic                     in_median_empty,
  output logic [7:0]               out_median,
  output logic                     out_median_wr,
  input  logic                     out_median_full,
  output logic                     busy,
  output logic [3:0]               inflight,
  output logic [15:0]              windows_done
);

  typedef enum logic [1:0] {IDLE, CFG, STREAM} state_t;

  localparam logic [BUFF_SIZE_BIT-1:0] LAST_PX = BUFF_SIZE_BIT'(BUFF_SIZE - 11'd1);
  localparam logic [3:0]               MAX_INF = 4'(MAX_INFLIGHT);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [BUFF_SIZE_BIT-1:0] r_px_cnt;
  logic [3:0]               r_inflight;
  logic [15:0]              r_windows_done;
  logic                     w_cfg_ok;
  logic                     w_cfg_fire;
  logic                     w_px_fire;
  logic                     w_ret_fire;

  assign out_pivot               = DEFAULT_PIVOT;
  assign out_buff_size           = BUFF_SIZE_BIT'(BUFF_SIZE);
  assign out_median_pos          = BUFF_SIZE_BIT'(MEDIAN_POS);
  assign out_second_median_value = DEFAULT_PIVOT;
  assign out_px                  = in_px;
  assign out_median              = in_median;

  // A token set is written only when every config FIFO can take its token.
  assign w_cfg_ok = ~(out_pivot_full | out_buff_size_full |
                      out_median_pos_full | out_second_median_value_full);

  assign out_pivot_wr               = w_cfg_fire;
  assign out_buff_size_wr           = w_cfg_fire;
  assign out_median_pos_wr          = w_cfg_fire;
  assign out_second_median_value_wr = w_cfg_fire;
  assign in_px_rd                   = w_px_fire;
  assign out_px_wr                  = w_px_fire;

  assign w_ret_fire    = ~in_median_empty & ~out_median_full;
  assign in_median_rd  = w_ret_fire;
  assign out_median_wr = w_ret_fire;

  assign busy         = (r_state != IDLE) || (r_inflight != '0);
  assign inflight     = r_inflight;
  assign windows_done = r_windows_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_fire  = 1'b0;
    w_px_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!in_px_empty && (r_inflight < MAX_INF)) w_state_nxt = CFG;
      end
      CFG: begin
        if (w_cfg_ok) begin
          w_cfg_fire  = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        w_px_fire = ~in_px_empty & ~out_px_full;
        if (w_px_fire && (r_px_cnt == LAST_PX)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_px_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cfg_fire)     r_px_cnt <= '0;
      else if (w_px_fire) r_px_cnt <= r_px_cnt + 1'b1;
    end
  end

  // Issue and retire in the same cycle cancel; a stray retire saturates at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inflight     <= '0;
      r_windows_done <= '0;
    end else begin
      if (w_cfg_fire && !w_ret_fire)
        r_inflight <= r_inflight + 1'b1;
      else if (w_ret_fire && !w_cfg_fire && (r_inflight != '0))
        r_inflight <= r_inflight - 1'b1;
      if (w_ret_fire) r_windows_done <= r_windows_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_median_window_sequencer.sv
// Bench for median_window_sequencer: FIFO models around the DUT, a transaction-level
// scoreboard, a scenario table, hand-written corner sequences and a randomized run.
module tb_median_window_sequencer;
  localparam int BW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_px;
  logic          in_px_rd, in_px_empty;
  logic [7:0]    out_px;
  logic          out_px_wr, out_px_full;
  logic [7:0]    out_pivot;
  logic          out_pivot_wr, out_pivot_full;
  logic [BW-1:0] out_buff_size;
  logic          out_buff_size_wr, out_buff_size_full;
  logic [BW-1:0] out_median_pos;
  logic          out_median_pos_wr, out_median_pos_full;
  logic [7:0]    out_second_median_value;
  logic          out_second_median_value_wr, out_second_median_value_full;
  logic [7:0]    in_median;
  logic          in_median_rd, in_median_empty;
  logic [7:0]    out_median;
  logic          out_median_wr, out_median_full;
  logic          busy;
  logic [3:0]    inflight;
  logic [15:0]   windows_done;

  median_window_sequencer #(.MAX_INFLIGHT(2)) dut (
    .clock(clock), .reset(reset),
    .in_px(in_px), .in_px_rd(in_px_rd), .in_px_empty(in_px_empty),
    .out_px(out_px), .out_px_wr(out_px_wr), .out_px_full(out_px_full),
    .out_pivot(out_pivot), .out_pivot_wr(out_pivot_wr), .out_pivot_full(out_pivot_full),
    .out_buff_size(out_buff_size), .out_buff_size_wr(out_buff_size_wr),
    .out_buff_size_full(out_buff_size_full),
    .out_median_pos(out_median_pos), .out_median_pos_wr(out_median_pos_wr),
    .out_median_pos_full(out_median_pos_full),
    .out_second_median_value(out_second_median_value),
    .out_second_median_value_wr(out_second_median_value_wr),
    .out_second_median_value_full(out_second_median_value_full),
    .in_median(in_median), .in_median_rd(in_median_rd), .in_median_empty(in_median_empty),
    .out_median(out_median), .out_median_wr(out_median_wr), .out_median_full(out_median_full),
    .busy(busy), .inflight(inflight), .windows_done(windows_done)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_bad = 0, cyc = 0;
  logic [7:0] src_q[$], exp_px_q[$], res_q[$], exp_res_q[$];
  int  m_inflight, m_done, m_px, fwd_cnt, cfg_cnt, res_pushed, last_cfg_cyc, last_ret_cyc;
  bit  m_open;
  int  px_cyc[$];
  bit  s_px, s_ret, s_cfg;

  typedef struct {
    int   npix;
    int   nres;
    int   fwd;
    int   infl;
    int   done;
    logic busy;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    in_px           = (src_q.size() != 0) ? src_q[0] : 8'd0;
    in_px_empty     = (src_q.size() == 0);
    in_median       = (res_q.size() != 0) ? res_q[0] : 8'd0;
    in_median_empty = (res_q.size() == 0);
  endtask

  task automatic push_px(input logic [7:0] v);
    src_q.push_back(v);
    exp_px_q.push_back(v);
  endtask

  task automatic push_res(input logic [7:0] v);
    res_q.push_back(v);
    exp_res_q.push_back(v);
  endtask

  task automatic set_fulls(input logic v);
    out_px_full = v; out_pivot_full = v; out_buff_size_full = v;
    out_median_pos_full = v; out_second_median_value_full = v; out_median_full = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_q.delete(); exp_px_q.delete(); res_q.delete(); exp_res_q.delete(); px_cyc.delete();
    set_fulls(1'b0);
    m_inflight = 0; m_done = 0; m_px = 0; m_open = 0;
    fwd_cnt = 0; cfg_cnt = 0; res_pushed = 0; last_cfg_cyc = -1; last_ret_cyc = -1;
    drive();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cyc = 0;
  endtask

  // One clock: drive FIFO fronts, judge handshakes at negedge, commit after posedge.
  task automatic cycle();
    drive();
    @(negedge clock);
    s_px  = in_px_rd | out_px_wr;
    s_ret = in_median_rd | out_median_wr;
    s_cfg = out_pivot_wr | out_buff_size_wr | out_median_pos_wr | out_second_median_value_wr;
    if (s_px) begin
      check("px_rd_eq_wr", in_px_rd, out_px_wr);
      check("px_full_respected", out_px_full, 0);
      check("px_src_nonempty", in_px_empty, 0);
      check("px_in_open_window", m_open, 1);
      if (exp_px_q.size() != 0) check("px_value", out_px, exp_px_q[0]);
    end
    if (s_cfg) begin
      check("cfg_all_wr", {out_pivot_wr, out_buff_size_wr, out_median_pos_wr,
                           out_second_median_value_wr}, 4'hF);
      check("cfg_full_respected", {out_pivot_full, out_buff_size_full, out_median_pos_full,
                                   out_second_median_value_full}, 0);
      check("cfg_after_window", m_open, 0);
      check("cfg_inflight_limit", int'(m_inflight < 2), 1);
      check("cfg_pivot", out_pivot, 127);
      check("cfg_size", out_buff_size, 8);
      check("cfg_pos", out_median_pos, 4);
      check("cfg_second", out_second_median_value, 127);
    end
    if (s_ret) begin
      check("ret_rd_eq_wr", in_median_rd, out_median_wr);
      check("ret_full_respected", out_median_full, 0);
      check("ret_src_nonempty", in_median_empty, 0);
      if (exp_res_q.size() != 0) check("ret_value", out_median, exp_res_q[0]);
    end
    @(posedge clock);
    #1;
    if (s_px) begin
      if (src_q.size() != 0) void'(src_q.pop_front());
      if (exp_px_q.size() != 0) void'(exp_px_q.pop_front());
      fwd_cnt++; m_px++; px_cyc.push_back(cyc);
      if (m_px == 8) m_open = 0;
    end
    if (s_cfg) begin
      m_open = 1; m_px = 0; cfg_cnt++; last_cfg_cyc = cyc;
    end
    if (s_ret) begin
      if (res_q.size() != 0) void'(res_q.pop_front());
      if (exp_res_q.size() != 0) void'(exp_res_q.pop_front());
      m_done = (m_done + 1) % 65536; last_ret_cyc = cyc;
    end
    if (s_cfg && !s_ret) m_inflight++;
    else if (s_ret && !s_cfg && m_inflight > 0) m_inflight--;
    check("inflight", inflight, m_inflight);
    check("windows_done", windows_done, m_done);
    cyc++;
  endtask

  initial begin
    int t;
    set_fulls(1'b0);
    tbl[0] = '{npix: 8,  nres: 0, fwd: 8,  infl: 1, done: 0, busy: 1'b1};
    tbl[1] = '{npix: 24, nres: 0, fwd: 16, infl: 2, done: 0, busy: 1'b1};
    tbl[2] = '{npix: 24, nres: 1, fwd: 16, infl: 2, done: 1, busy: 1'b1};
    tbl[3] = '{npix: 5,  nres: 0, fwd: 5,  infl: 1, done: 0, busy: 1'b1};
    tbl[4] = '{npix: 0,  nres: 0, fwd: 0,  infl: 0, done: 0, busy: 1'b0};
    tbl[5] = '{npix: 0,  nres: 2, fwd: 0,  infl: 0, done: 2, busy: 1'b0};

    do_reset();
    check("rst_inflight", inflight, 0);
    check("rst_done", windows_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_wr", out_pivot_wr, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int k = 0; k < tbl[v].nres; k++) push_res(8'(k + 1));
      for (int i = 0; i < tbl[v].npix; i++) push_px(8'(i * 7 + 3));
      repeat (60) cycle();
      check("tbl_fwd", fwd_cnt, tbl[v].fwd);
      check("tbl_inflight", inflight, tbl[v].infl);
      check("tbl_done", windows_done, tbl[v].done);
      check("tbl_busy", busy, tbl[v].busy);
    end

    // Single window latency and retire.
    do_reset();
    for (int i = 1; i <= 8; i++) push_px(8'(i));
    repeat (12) cycle();
    check("lat_cfg_cycle", last_cfg_cyc, 1);
    check("lat_first_px", (px_cyc.size() > 0) ? px_cyc[0] : -1, 2);
    check("lat_last_px", (px_cyc.size() > 7) ? px_cyc[7] : -1, 9);
    push_res(8'd4);
    t = cyc;
    cycle();
    check("ret_cycle", last_ret_cyc, t);
    check("ret_busy_after", busy, 0);

    // Pivot FIFO full while in CFG.
    do_reset();
    for (int i = 0; i < 8; i++) push_px(8'(40 + i));
    out_pivot_full = 1'b1;
    repeat (4) cycle();
    check("pfull_no_cfg", cfg_cnt, 0);
    check("pfull_no_px", fwd_cnt, 0);
    out_pivot_full = 1'b0;
    repeat (10) cycle();
    check("pfull_cfg_cycle", last_cfg_cyc, 4);
    check("pfull_first_px", (px_cyc.size() > 0) ? px_cyc[0] : -1, 5);
    check("pfull_fwd", fwd_cnt, 8);

    // Inflight limit parks the FSM; one retire lets the third window start.
    do_reset();
    for (int i = 0; i < 24; i++) push_px(8'(i + 60));
    repeat (30) cycle();
    check("lim_fwd", fwd_cnt, 16);
    check("lim_cfg", cfg_cnt, 2);
    check("lim_inflight", inflight, 2);
    push_res(8'd9);
    t = cyc;
    repeat (4) cycle();
    check("lim_third_cfg", cfg_cnt, 3);
    check("lim_third_lat", int'((last_cfg_cyc - t) >= 1 && (last_cfg_cyc - t) <= 2), 1);

    // out_px_full toggling during STREAM.
    do_reset();
    for (int i = 0; i < 16; i++) push_px(8'(200 - i));
    for (int c = 0; c < 44; c++) begin
      out_px_full = cyc[0];
      cycle();
    end
    out_px_full = 1'b0;
    check("tog_fwd", fwd_cnt, 16);
    check("tog_cfg", cfg_cnt, 2);

    // Retire coinciding with a config write at inflight 1.
    do_reset();
    for (int i = 0; i < 8; i++) push_px(8'(i));
    repeat (12) cycle();
    check("coin_pre_inflight", inflight, 1);
    for (int i = 0; i < 8; i++) push_px(8'(i + 16));
    t = cyc;
    cycle();
    push_res(8'd77);
    cycle();
    check("coin_cfg_cycle", last_cfg_cyc, t + 1);
    check("coin_ret_cycle", last_ret_cyc, t + 1);
    check("coin_inflight", inflight, 1);
    check("coin_done", windows_done, 1);

    // Reset mid-window after pixel 5.
    do_reset();
    for (int i = 0; i < 8; i++) push_px(8'(i + 90));
    repeat (7) cycle();
    check("mid_fwd5", fwd_cnt, 5);
    reset = 1'b1;
    #1;
    check("arst_px_rd", in_px_rd, 0);
    check("arst_cfg_wr", out_pivot_wr, 0);
    check("arst_busy", busy, 0);
    check("arst_inflight", inflight, 0);
    do_reset();
    for (int i = 0; i < 8; i++) push_px(8'(i + 101));
    repeat (12) cycle();
    check("restart_cfg", cfg_cnt, 1);
    check("restart_fwd", fwd_cnt, 8);

    // Randomized traffic with random back-pressure and result timing.
    do_reset();
    for (int i = 0; i < 96; i++) push_px(8'($urandom));
    for (int c = 0; c < 4000 && m_done < 12; c++) begin
      out_px_full                  = ($urandom_range(0, 3) == 0);
      out_pivot_full               = ($urandom_range(0, 7) == 0);
      out_buff_size_full           = ($urandom_range(0, 7) == 0);
      out_median_pos_full          = ($urandom_range(0, 7) == 0);
      out_second_median_value_full = ($urandom_range(0, 7) == 0);
      out_median_full              = ($urandom_range(0, 3) == 0);
      if (res_pushed < cfg_cnt && $urandom_range(0, 2) == 0) begin
        push_res(8'($urandom));
        res_pushed++;
      end
      cycle();
    end
    set_fulls(1'b0);
    check("rand_done", windows_done, 12);
    check("rand_fwd", fwd_cnt, 96);
    check("rand_inflight", inflight, 0);
    check("rand_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
